// File: rtl/avmm_sram_ctrl.sv
// Avalon-MM slave bridging one non-pipelined read or write at a time onto a
// single-port synchronous SRAM, with saturating access counters and sticky error flags.
module avmm_sram_ctrl #(
  parameter int SRAM_AW     = 16,
  parameter int RD_LAT      = 2,
  parameter int WAIT_STATES = 1,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               avs_s0_chipselect,
  input  logic [31:0]        avs_s0_address,
  input  logic               avs_s0_read,
  input  logic               avs_s0_write,
  input  logic [31:0]        avs_s0_writedata,
  input  logic [3:0]         avs_s0_byteenable,
  output logic [31:0]        avs_s0_readdata,
  output logic               avs_s0_readdatavalid,
  output logic               avs_s0_waitrequest,
  output logic               sram_ce,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  output logic [3:0]         sram_be,
  input  logic [31:0]        sram_rdata,
  output logic [CNT_W-1:0]   wr_count,
  output logic [CNT_W-1:0]   rd_count,
  output logic               range_err,
  output logic               protocol_err
);

  localparam int TW = 8;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_ACK} state_e;

  state_e             state_q, state_d;
  logic [TW-1:0]      cnt_q;
  logic               op_wr_q;
  logic               strobe_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic               ce_q, we_q;
  logic [31:0]        rdata_q;
  logic [CNT_W-1:0]   wr_cnt_q, rd_cnt_q;
  logic               range_err_q, proto_err_q;

  logic accept, in_range, do_strobe, cnt_zero;
  logic unused_addr_bits;

  assign accept    = avs_s0_chipselect && (avs_s0_read || avs_s0_write);
  assign in_range  = (avs_s0_address[31:SRAM_AW+2] == '0);
  // A write with no enabled byte lanes keeps full timing but never touches the SRAM.
  assign do_strobe = in_range && (!avs_s0_write || (avs_s0_byteenable != 4'b0000));
  assign cnt_zero  = (cnt_q == '0);
  assign unused_addr_bits = ^avs_s0_address[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept) state_d = avs_s0_write ? S_WR : S_RD;
      S_WR, S_RD: if (cnt_zero) state_d = S_ACK;
      S_ACK:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    avs_s0_waitrequest   = (state_q != S_ACK);
    avs_s0_readdatavalid = (state_q == S_ACK) && !op_wr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      strobe_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      ce_q        <= 1'b0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      range_err_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      ce_q <= 1'b0;
      we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_wr_q  <= avs_s0_write;
            strobe_q <= do_strobe;
            addr_q   <= avs_s0_address[SRAM_AW+1:2];
            wdata_q  <= avs_s0_writedata;
            be_q     <= avs_s0_byteenable;
            ce_q     <= do_strobe;
            we_q     <= do_strobe && avs_s0_write;
            cnt_q    <= avs_s0_write ? TW'(WAIT_STATES) : TW'(RD_LAT);
            if (!in_range) range_err_q <= 1'b1;
            if (avs_s0_read && avs_s0_write) proto_err_q <= 1'b1;
          end
        end
        S_WR, S_RD: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // An unstrobed read (out of range) returns zero rather than stale SRAM output.
            if (state_q == S_RD) rdata_q <= strobe_q ? sram_rdata : 32'h0;
            if (strobe_q && op_wr_q && (wr_cnt_q != {CNT_W{1'b1}})) wr_cnt_q <= wr_cnt_q + 1'b1;
            if (strobe_q && !op_wr_q && (rd_cnt_q != {CNT_W{1'b1}})) rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign avs_s0_readdata = rdata_q;
  assign sram_ce         = ce_q;
  assign sram_we         = we_q;
  assign sram_addr       = addr_q;
  assign sram_wdata      = wdata_q;
  assign sram_be         = be_q;
  assign wr_count        = wr_cnt_q;
  assign rd_count        = rd_cnt_q;
  assign range_err       = range_err_q;
  assign protocol_err    = proto_err_q;

endmodule

// File: tb/tb_avmm_sram_ctrl.sv
// Bench for avmm_sram_ctrl: directed and random Avalon-MM transactions against a
// word-level memory/counter model, plus a behavioural SRAM with RD_LAT read pipeline.
module tb_avmm_sram_ctrl;

  localparam int SRAM_AW     = 16;
  localparam int RD_LAT      = 2;
  localparam int WAIT_STATES = 1;
  localparam int CNT_W       = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic               clk;
  logic               reset;
  logic               avs_s0_chipselect;
  logic [31:0]        avs_s0_address;
  logic               avs_s0_read;
  logic               avs_s0_write;
  logic [31:0]        avs_s0_writedata;
  logic [3:0]         avs_s0_byteenable;
  logic [31:0]        avs_s0_readdata;
  logic               avs_s0_readdatavalid;
  logic               avs_s0_waitrequest;
  logic               sram_ce;
  logic               sram_we;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_wdata;
  logic [3:0]         sram_be;
  logic [31:0]        sram_rdata;
  logic [CNT_W-1:0]   wr_count;
  logic [CNT_W-1:0]   rd_count;
  logic               range_err;
  logic               protocol_err;

  avmm_sram_ctrl #(
    .SRAM_AW(SRAM_AW), .RD_LAT(RD_LAT), .WAIT_STATES(WAIT_STATES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .avs_s0_chipselect(avs_s0_chipselect), .avs_s0_address(avs_s0_address),
    .avs_s0_read(avs_s0_read), .avs_s0_write(avs_s0_write),
    .avs_s0_writedata(avs_s0_writedata), .avs_s0_byteenable(avs_s0_byteenable),
    .avs_s0_readdata(avs_s0_readdata), .avs_s0_readdatavalid(avs_s0_readdatavalid),
    .avs_s0_waitrequest(avs_s0_waitrequest),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_be(sram_be), .sram_rdata(sram_rdata),
    .wr_count(wr_count), .rd_count(rd_count),
    .range_err(range_err), .protocol_err(protocol_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural SRAM: word 4 powers up as 0xCAFE_F00D, everything else as zero
  logic [31:0] sram_mem [int];
  logic [31:0] rd_pipe [RD_LAT];
  int          ce_pulses = 0;
  logic [SRAM_AW-1:0] last_addr = '0;
  logic [3:0]  last_be = '0;
  logic        last_we = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] power_up(input int idx);
    return (idx == 4) ? 32'hCAFE_F00D : 32'h0;
  endfunction

  always @(posedge clk) begin
    logic [31:0] cur;
    cur = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : power_up(int'(sram_addr));
    if (sram_ce && sram_we) sram_mem[int'(sram_addr)] = merge(cur, sram_wdata, sram_be);
    rd_pipe[0] <= (sram_ce && !sram_we) ? cur : 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (sram_ce) begin
      ce_pulses <= ce_pulses + 1;
      last_addr <= sram_addr;
      last_be   <= sram_be;
      last_we   <= sram_we;
    end
  end
  assign sram_rdata = rd_pipe[RD_LAT-1];

  // reference model
  logic [31:0] exp_mem [int];
  int          exp_wr, exp_rd;
  logic        exp_range, exp_proto;
  logic [31:0] exp_last_rd;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic model_reset();
    exp_wr = 0; exp_rd = 0; exp_range = 1'b0; exp_proto = 1'b0; exp_last_rd = 32'h0;
  endtask

  // driver: called just after a posedge; returns just after the posedge closing ACK
  task automatic txn(input logic wr, input logic rd, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] be);
    int          ce0, hold, exp_hold, idx;
    logic        done, rdv, in_rng, strobe;
    logic [31:0] rdat, cur, exp_data;
    in_rng = ((addr >> (SRAM_AW + 2)) == 32'h0);
    idx    = int'((addr >> 2) & ((32'h1 << SRAM_AW) - 1));
    strobe = in_rng && (!wr || (be != 4'b0000));
    ce0    = ce_pulses;
    avs_s0_chipselect = 1'b1; avs_s0_write = wr; avs_s0_read = rd;
    avs_s0_address = addr; avs_s0_writedata = data; avs_s0_byteenable = be;
    hold = 0; done = 1'b0; rdv = 1'b0; rdat = 32'h0;
    while (!done && hold < 40) begin
      @(negedge clk);
      hold++;
      if (!avs_s0_waitrequest) begin
        done = 1'b1; rdv = avs_s0_readdatavalid; rdat = avs_s0_readdata;
      end
    end
    @(posedge clk); #1;
    avs_s0_chipselect = 1'b0; avs_s0_write = 1'b0; avs_s0_read = 1'b0;

    cur = exp_mem.exists(idx) ? exp_mem[idx] : power_up(idx);
    if (wr) begin
      exp_hold = WAIT_STATES + 3;
      if (strobe) begin
        exp_mem[idx] = merge(cur, data, be);
        exp_wr = sat_inc(exp_wr);
      end
      if (rd) exp_proto = 1'b1;
    end else begin
      exp_hold = RD_LAT + 3;
      exp_data = in_rng ? cur : 32'h0;
      if (in_rng) exp_rd = sat_inc(exp_rd);
      exp_last_rd = exp_data;
    end
    if (!in_rng) exp_range = 1'b1;

    chk("ack_seen", 32'(done), 32'd1);
    chk("hold_cycles", 32'(hold), 32'(exp_hold));
    chk("readdatavalid", 32'(rdv), 32'(!wr));
    chk("readdata", rdat, exp_last_rd);
    chk("strobe_count", 32'(ce_pulses - ce0), 32'(strobe));
    if (strobe) begin
      chk("sram_addr", 32'(last_addr), 32'(idx));
      chk("sram_we", 32'(last_we), 32'(wr));
      if (wr) chk("sram_be", 32'(last_be), 32'(be));
    end
    chk("wr_count", 32'(wr_count), 32'(exp_wr));
    chk("rd_count", 32'(rd_count), 32'(exp_rd));
    chk("range_err", 32'(range_err), 32'(exp_range));
    chk("protocol_err", 32'(protocol_err), 32'(exp_proto));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_waitreq"}, 32'(avs_s0_waitrequest), 32'd1);
    chk({tag, "_rdvalid"}, 32'(avs_s0_readdatavalid), 32'd0);
    chk({tag, "_rdata"}, avs_s0_readdata, 32'h0);
    chk({tag, "_ce"}, 32'(sram_ce), 32'd0);
    chk({tag, "_we"}, 32'(sram_we), 32'd0);
    chk({tag, "_addr"}, 32'(sram_addr), 32'd0);
    chk({tag, "_wdata"}, sram_wdata, 32'h0);
    chk({tag, "_be"}, 32'(sram_be), 32'd0);
    chk({tag, "_cnts"}, 32'({wr_count, rd_count}), 32'd0);
    chk({tag, "_errs"}, 32'({range_err, protocol_err}), 32'd0);
  endtask

  initial begin
    int acks, ce0;
    logic [31:0] a;
    logic        w, r;
    reset = 1'b0;
    avs_s0_chipselect = 1'b0; avs_s0_read = 1'b0; avs_s0_write = 1'b0;
    avs_s0_address = 32'h0; avs_s0_writedata = 32'h0; avs_s0_byteenable = 4'h0;
    model_reset();
    #12;
    chk_reset_values("por");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // R1 then W1 then readback, all back to back
    txn(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    chk("r1_data", avs_s0_readdata, 32'hCAFE_F00D);
    txn(1'b1, 1'b0, 32'h10, 32'hA5A5_1234, 4'b0101);
    chk("w1_wr_count", 32'(wr_count), 32'd1);
    txn(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    chk("merged_readback", avs_s0_readdata, 32'hCAA5_F034);

    // chipselect low: request ignored
    avs_s0_read = 1'b1; avs_s0_address = 32'h10; acks = 0; ce0 = ce_pulses;
    repeat (4) begin @(negedge clk); if (!avs_s0_waitrequest) acks++; end
    avs_s0_read = 1'b0;
    chk("no_cs_acks", 32'(acks), 32'd0);
    chk("no_cs_strobes", 32'(ce_pulses - ce0), 32'd0);
    @(posedge clk); #1;

    // error cases and zero byteenable
    txn(1'b0, 1'b1, 32'h0004_0000, 32'h0, 4'h0);
    txn(1'b1, 1'b1, 32'h20, 32'h1122_3344, 4'b1111);
    txn(1'b0, 1'b1, 32'h20, 32'h0, 4'h0);
    txn(1'b1, 1'b0, 32'h30, 32'hFFFF_FFFF, 4'b0000);
    txn(1'b0, 1'b1, 32'h30, 32'h0, 4'h0);

    // counter saturation
    for (int i = 0; i < 5; i++) txn(1'b1, 1'b0, 32'(i * 4 + 64), $urandom, 4'b1111);
    chk("wr_saturated", 32'(wr_count), 32'(CNT_MAX));

    // random traffic with random idle gaps
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      r = !w || ($urandom_range(0, 15) == 0);
      a = 32'($urandom_range(0, 7)) << 2;
      if ($urandom_range(0, 9) == 0) a = a | (32'($urandom_range(1, 16383)) << 18);
      txn(w, r, a, $urandom, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // reset while the read strobe is on the SRAM
    avs_s0_chipselect = 1'b1; avs_s0_read = 1'b1; avs_s0_address = 32'h10;
    @(posedge clk); #1;
    chk("pre_reset_ce", 32'(sram_ce), 32'd1);
    reset = 1'b0;
    #1;
    chk_reset_values("midrd");
    avs_s0_chipselect = 1'b0; avs_s0_read = 1'b0;
    model_reset();
    acks = 0;
    repeat (3) begin @(negedge clk); if (!avs_s0_waitrequest) acks++; end
    chk("reset_no_ack", 32'(acks), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
